// File: rtl/cache_burst_adapter_pkg.sv
// Shared types and geometry helpers for the cache-to-fabric burst adapter.
package cache_burst_adapter_pkg;

  localparam int DEF_LINE_SIZE = 64;
  localparam int DEF_BEAT_SIZE = 16;
  localparam int DEF_BEATS     = DEF_LINE_SIZE / DEF_BEAT_SIZE;

  // A beat counter is never narrower than one bit, even for single-beat lines.
  function automatic int calc_beat_bits(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  localparam int DEF_BEAT_BITS = calc_beat_bits(DEF_BEATS);

  typedef enum logic [0:0] {
    REQ_IDLE   = 1'b0,
    REQ_WBURST = 1'b1
  } req_state_e;

endpackage

// File: rtl/cache_burst_assembler.sv
// Collects narrow read-response beats into a line buffer and presents the
// completed line to the cache, holding it until accepted.
module cache_burst_assembler
  import cache_burst_adapter_pkg::*;
#(
  parameter int LINE_SIZE = 64,
  parameter int BEAT_SIZE = 16,
  parameter int TAG_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   out_rsp_valid,
  input  logic [BEAT_SIZE*8-1:0] out_rsp_data,
  input  logic [TAG_WIDTH-1:0]   out_rsp_tag,
  input  logic                   out_rsp_last,
  output logic                   out_rsp_ready,
  output logic                   in_rsp_valid,
  output logic [LINE_SIZE*8-1:0] in_rsp_data,
  output logic [TAG_WIDTH-1:0]   in_rsp_tag,
  input  logic                   in_rsp_ready
);

  localparam int BEATS     = LINE_SIZE / BEAT_SIZE;
  localparam int BEAT_BITS = calc_beat_bits(BEATS);
  localparam int BEAT_W    = BEAT_SIZE * 8;

  logic [BEAT_BITS-1:0]   rsp_cnt_q, rsp_cnt_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [LINE_SIZE*8-1:0] line_q, line_d;
  logic                   beat_fire, line_done;

  always_comb begin
    out_rsp_ready = !rsp_valid_q || in_rsp_ready;
    beat_fire     = out_rsp_valid && out_rsp_ready;
    line_done     = beat_fire && (rsp_cnt_q == BEAT_BITS'(BEATS - 1));
    rsp_cnt_d     = rsp_cnt_q;
    tag_d         = tag_q;
    line_d        = line_q;
    if (beat_fire) begin
      rsp_cnt_d = line_done ? '0 : rsp_cnt_q + 1'b1;
      tag_d     = out_rsp_tag;
      line_d[int'(rsp_cnt_q)*BEAT_W +: BEAT_W] = out_rsp_data;
    end
    // A freshly completed line wins over the consumption of the previous one.
    if (line_done)         rsp_valid_d = 1'b1;
    else if (in_rsp_ready) rsp_valid_d = 1'b0;
    else                   rsp_valid_d = rsp_valid_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      rsp_cnt_q   <= rsp_cnt_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    line_q <= line_d;
  end

  assign in_rsp_valid = rsp_valid_q;
  assign in_rsp_data  = line_q;
  assign in_rsp_tag   = tag_q;

  a_last_matches_count : assert property (@(posedge clk) disable iff (reset)
    out_rsp_valid |-> (out_rsp_last == (rsp_cnt_q == BEAT_BITS'(BEATS - 1))))
    else $error("out_rsp_last disagrees with beat position");

  a_tag_constant : assert property (@(posedge clk) disable iff (reset)
    (out_rsp_valid && rsp_cnt_q != '0) |-> (out_rsp_tag == tag_q))
    else $error("response tag changed within one line");

endmodule

// File: rtl/cache_burst_adapter.sv
// Splits line-wide cache requests into narrow fabric beats and reassembles
// narrow read responses into line-wide responses.
module cache_burst_adapter
  import cache_burst_adapter_pkg::*;
#(
  parameter int LINE_SIZE  = 64,
  parameter int BEAT_SIZE  = 16,
  parameter int ADDR_WIDTH = 26,
  parameter int TAG_WIDTH  = 8,
  localparam int BEATS     = LINE_SIZE / BEAT_SIZE,
  localparam int BEAT_BITS = calc_beat_bits(BEATS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_req_valid,
  input  logic                            in_req_rw,
  input  logic [LINE_SIZE-1:0]            in_req_byteen,
  input  logic [ADDR_WIDTH-1:0]           in_req_addr,
  input  logic [LINE_SIZE*8-1:0]          in_req_data,
  input  logic [TAG_WIDTH-1:0]            in_req_tag,
  output logic                            in_req_ready,
  output logic                            in_rsp_valid,
  output logic [LINE_SIZE*8-1:0]          in_rsp_data,
  output logic [TAG_WIDTH-1:0]            in_rsp_tag,
  input  logic                            in_rsp_ready,
  output logic                            out_req_valid,
  output logic                            out_req_rw,
  output logic [ADDR_WIDTH+BEAT_BITS-1:0] out_req_addr,
  output logic [BEAT_SIZE-1:0]            out_req_byteen,
  output logic [BEAT_SIZE*8-1:0]          out_req_data,
  output logic [TAG_WIDTH-1:0]            out_req_tag,
  output logic                            out_req_last,
  input  logic                            out_req_ready,
  input  logic                            out_rsp_valid,
  input  logic [BEAT_SIZE*8-1:0]          out_rsp_data,
  input  logic [TAG_WIDTH-1:0]            out_rsp_tag,
  input  logic                            out_rsp_last,
  output logic                            out_rsp_ready
);

  localparam int BEAT_W = BEAT_SIZE * 8;

  if (LINE_SIZE % BEAT_SIZE != 0) begin : g_bad_geometry
    $error("LINE_SIZE must be a whole multiple of BEAT_SIZE");
  end

  typedef struct packed {
    logic                            rw;
    logic [ADDR_WIDTH+BEAT_BITS-1:0] addr;
    logic [BEAT_SIZE-1:0]            byteen;
    logic [BEAT_W-1:0]               data;
    logic [TAG_WIDTH-1:0]            tag;
    logic                            last;
  } beat_req_t;

  req_state_e             state_q, state_d;
  logic [BEAT_BITS-1:0]   req_cnt_q, req_cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [LINE_SIZE-1:0]   byteen_q, byteen_d;
  logic [LINE_SIZE*8-1:0] data_q, data_d;
  beat_req_t              beat;

  // NOTE: every output of this block is given a default first so no path
  // through the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    req_cnt_d     = req_cnt_q;
    addr_d        = addr_q;
    tag_d         = tag_q;
    byteen_d      = byteen_q;
    data_d        = data_q;
    beat          = '0;
    out_req_valid = 1'b0;
    in_req_ready  = 1'b0;
    unique case (state_q)
      REQ_IDLE: begin
        in_req_ready  = out_req_ready;
        out_req_valid = in_req_valid;
        beat.rw       = in_req_rw;
        beat.addr     = {in_req_addr, BEAT_BITS'(0)};
        beat.byteen   = in_req_rw ? in_req_byteen[BEAT_SIZE-1:0] : '1;
        beat.data     = in_req_data[BEAT_W-1:0];
        beat.tag      = in_req_tag;
        beat.last     = !in_req_rw || (BEATS == 1);
        if (in_req_valid && out_req_ready && in_req_rw && (BEATS > 1)) begin
          addr_d    = in_req_addr;
          tag_d     = in_req_tag;
          byteen_d  = in_req_byteen;
          data_d    = in_req_data;
          req_cnt_d = BEAT_BITS'(1);
          state_d   = REQ_WBURST;
        end
      end
      REQ_WBURST: begin
        out_req_valid = 1'b1;
        beat.rw       = 1'b1;
        beat.addr     = {addr_q, req_cnt_q};
        beat.byteen   = byteen_q[int'(req_cnt_q)*BEAT_SIZE +: BEAT_SIZE];
        beat.data     = data_q[int'(req_cnt_q)*BEAT_W +: BEAT_W];
        beat.tag      = tag_q;
        beat.last     = (req_cnt_q == BEAT_BITS'(BEATS - 1));
        if (out_req_ready) begin
          req_cnt_d = beat.last ? '0 : req_cnt_q + 1'b1;
          if (beat.last) state_d = REQ_IDLE;
        end
      end
      default: state_d = REQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= REQ_IDLE;
      req_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      req_cnt_q <= req_cnt_d;
    end
  end

  // NOTE: the latched line is only ever read while in WBURST, which is entered
  // by the same cycle that loads it, so these wide registers carry no reset.
  always_ff @(posedge clk) begin
    addr_q   <= addr_d;
    tag_q    <= tag_d;
    byteen_q <= byteen_d;
    data_q   <= data_d;
  end

  assign out_req_rw     = beat.rw;
  assign out_req_addr   = beat.addr;
  assign out_req_byteen = beat.byteen;
  assign out_req_data   = beat.data;
  assign out_req_tag    = beat.tag;
  assign out_req_last   = beat.last;

  cache_burst_assembler #(
    .LINE_SIZE (LINE_SIZE),
    .BEAT_SIZE (BEAT_SIZE),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_assembler (
    .clk           (clk),
    .reset         (reset),
    .out_rsp_valid (out_rsp_valid),
    .out_rsp_data  (out_rsp_data),
    .out_rsp_tag   (out_rsp_tag),
    .out_rsp_last  (out_rsp_last),
    .out_rsp_ready (out_rsp_ready),
    .in_rsp_valid  (in_rsp_valid),
    .in_rsp_data   (in_rsp_data),
    .in_rsp_tag    (in_rsp_tag),
    .in_rsp_ready  (in_rsp_ready)
  );

endmodule

// File: tb/tb_cache_burst_adapter.sv
// Directed bench for cache_burst_adapter: a 4-beat instance and a 1-beat
// instance driven with hand-computed vectors.
module tb_cache_burst_adapter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // 4-beat instance (LINE 64 / BEAT 16)
  logic         in_req_valid, in_req_rw, in_req_ready;
  logic [63:0]  in_req_byteen;
  logic [25:0]  in_req_addr;
  logic [511:0] in_req_data;
  logic [7:0]   in_req_tag;
  logic         in_rsp_valid, in_rsp_ready;
  logic [511:0] in_rsp_data;
  logic [7:0]   in_rsp_tag;
  logic         out_req_valid, out_req_rw, out_req_last, out_req_ready;
  logic [27:0]  out_req_addr;
  logic [15:0]  out_req_byteen;
  logic [127:0] out_req_data;
  logic [7:0]   out_req_tag;
  logic         out_rsp_valid, out_rsp_last, out_rsp_ready;
  logic [127:0] out_rsp_data;
  logic [7:0]   out_rsp_tag;

  // 1-beat instance (LINE 64 / BEAT 64)
  logic         b_in_req_valid, b_in_req_rw, b_in_req_ready;
  logic [63:0]  b_in_req_byteen;
  logic [25:0]  b_in_req_addr;
  logic [511:0] b_in_req_data;
  logic [7:0]   b_in_req_tag;
  logic         b_in_rsp_valid, b_in_rsp_ready;
  logic [511:0] b_in_rsp_data;
  logic [7:0]   b_in_rsp_tag;
  logic         b_out_req_valid, b_out_req_rw, b_out_req_last, b_out_req_ready;
  logic [26:0]  b_out_req_addr;
  logic [63:0]  b_out_req_byteen;
  logic [511:0] b_out_req_data;
  logic [7:0]   b_out_req_tag;
  logic         b_out_rsp_valid, b_out_rsp_last, b_out_rsp_ready;
  logic [511:0] b_out_rsp_data;
  logic [7:0]   b_out_rsp_tag;

  cache_burst_adapter u_dut (
    .clk (clk), .reset (reset),
    .in_req_valid (in_req_valid), .in_req_rw (in_req_rw), .in_req_byteen (in_req_byteen),
    .in_req_addr (in_req_addr), .in_req_data (in_req_data), .in_req_tag (in_req_tag),
    .in_req_ready (in_req_ready),
    .in_rsp_valid (in_rsp_valid), .in_rsp_data (in_rsp_data), .in_rsp_tag (in_rsp_tag),
    .in_rsp_ready (in_rsp_ready),
    .out_req_valid (out_req_valid), .out_req_rw (out_req_rw), .out_req_addr (out_req_addr),
    .out_req_byteen (out_req_byteen), .out_req_data (out_req_data), .out_req_tag (out_req_tag),
    .out_req_last (out_req_last), .out_req_ready (out_req_ready),
    .out_rsp_valid (out_rsp_valid), .out_rsp_data (out_rsp_data), .out_rsp_tag (out_rsp_tag),
    .out_rsp_last (out_rsp_last), .out_rsp_ready (out_rsp_ready)
  );

  cache_burst_adapter #(.BEAT_SIZE(64)) u_dut_b1 (
    .clk (clk), .reset (reset),
    .in_req_valid (b_in_req_valid), .in_req_rw (b_in_req_rw), .in_req_byteen (b_in_req_byteen),
    .in_req_addr (b_in_req_addr), .in_req_data (b_in_req_data), .in_req_tag (b_in_req_tag),
    .in_req_ready (b_in_req_ready),
    .in_rsp_valid (b_in_rsp_valid), .in_rsp_data (b_in_rsp_data), .in_rsp_tag (b_in_rsp_tag),
    .in_rsp_ready (b_in_rsp_ready),
    .out_req_valid (b_out_req_valid), .out_req_rw (b_out_req_rw), .out_req_addr (b_out_req_addr),
    .out_req_byteen (b_out_req_byteen), .out_req_data (b_out_req_data), .out_req_tag (b_out_req_tag),
    .out_req_last (b_out_req_last), .out_req_ready (b_out_req_ready),
    .out_rsp_valid (b_out_rsp_valid), .out_rsp_data (b_out_rsp_data), .out_rsp_tag (b_out_rsp_tag),
    .out_rsp_last (b_out_rsp_last), .out_rsp_ready (b_out_rsp_ready)
  );

  // Byte i of the line is i ^ x.
  function automatic logic [511:0] line_pat(input logic [7:0] x);
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[i*8 +: 8] = 8'(i) ^ x;
    return r;
  endfunction

  function automatic logic [127:0] beat_pat(input logic [7:0] b);
    return {16{b}};
  endfunction

  task automatic idle_inputs();
    in_req_valid = 0; in_req_rw = 0; in_req_byteen = '0; in_req_addr = '0;
    in_req_data = '0; in_req_tag = '0; in_rsp_ready = 1; out_req_ready = 1;
    out_rsp_valid = 0; out_rsp_data = '0; out_rsp_tag = '0; out_rsp_last = 0;
    b_in_req_valid = 0; b_in_req_rw = 0; b_in_req_byteen = '0; b_in_req_addr = '0;
    b_in_req_data = '0; b_in_req_tag = '0; b_in_rsp_ready = 1; b_out_req_ready = 1;
    b_out_rsp_valid = 0; b_out_rsp_data = '0; b_out_rsp_tag = '0; b_out_rsp_last = 0;
  endtask

  // Drives one response beat into the 4-beat instance and waits until it is taken.
  task automatic send_rsp(input logic [127:0] d, input logic [7:0] t, input logic l);
    bit ok;
    ok = 0;
    out_rsp_valid = 1; out_rsp_data = d; out_rsp_tag = t; out_rsp_last = l;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk); ok = out_rsp_ready;
      @(posedge clk); #1;
    end
    out_rsp_valid = 0; out_rsp_last = 0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rsp_beat_accept: beat %h not taken within 20 cycles", d); end
  endtask

  task automatic test_reset();
    idle_inputs();
    in_rsp_ready = 0;
    reset = 1;
    #1;
    n_checks++;
    if ({in_rsp_valid, out_req_valid, out_rsp_ready, in_req_ready} !== 4'b0011) begin
      n_fail++; $display("FAIL reset_state: got %b expected 0011",
        {in_rsp_valid, out_req_valid, out_rsp_ready, in_req_ready});
    end
    out_req_ready = 0; #1;
    n_checks++;
    if (in_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready_follow: got %b expected 0", in_req_ready);
    end
    out_req_ready = 1; in_rsp_ready = 1;
    @(posedge clk); #1 reset = 0;
  endtask

  task automatic test_read();
    logic [511:0] exp_line;
    in_req_valid = 1; in_req_rw = 0; in_req_addr = 26'h100; in_req_tag = 8'd5;
    in_req_byteen = '0; in_req_data = line_pat(8'h11); out_req_ready = 1;
    #1;
    n_checks++;
    if ({out_req_valid, out_req_rw, out_req_last, in_req_ready} !== 4'b1011) begin
      n_fail++; $display("FAIL read_ctrl: got %b expected 1011",
        {out_req_valid, out_req_rw, out_req_last, in_req_ready});
    end
    n_checks++;
    if ({out_req_addr, out_req_byteen, out_req_tag} !== {28'h400, 16'hFFFF, 8'd5}) begin
      n_fail++; $display("FAIL read_beat: got addr %h be %h tag %h expected 400 ffff 05",
        out_req_addr, out_req_byteen, out_req_tag);
    end
    @(posedge clk); #1 in_req_valid = 0;
    @(negedge clk);
    n_checks++;
    if (out_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL read_single_beat: out_req_valid %b expected 0", out_req_valid);
    end
    @(posedge clk); #1;
    in_rsp_ready = 0;
    for (int k = 0; k < 3; k++) send_rsp(beat_pat(8'(8'hD0 + k)), 8'd5, 1'b0);
    n_checks++;
    if (in_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL read_rsp_early: in_rsp_valid %b expected 0", in_rsp_valid);
    end
    send_rsp(beat_pat(8'hD3), 8'd5, 1'b1);
    exp_line = {beat_pat(8'hD3), beat_pat(8'hD2), beat_pat(8'hD1), beat_pat(8'hD0)};
    n_checks++;
    if ({in_rsp_valid, in_rsp_tag} !== {1'b1, 8'd5}) begin
      n_fail++; $display("FAIL read_rsp_valid: got valid %b tag %h expected 1 05", in_rsp_valid, in_rsp_tag);
    end
    n_checks++;
    if (in_rsp_data !== exp_line) begin
      n_fail++; $display("FAIL read_rsp_data: got %h expected %h", in_rsp_data, exp_line);
    end
    in_rsp_ready = 1;
    @(posedge clk); #1;
    n_checks++;
    if (in_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL read_rsp_consumed: in_rsp_valid %b expected 0", in_rsp_valid);
    end
  endtask

  task automatic test_write();
    logic [511:0] line;
    logic [15:0]  exp_be [4];
    exp_be = '{16'h00FF, 16'hFFFF, 16'h0000, 16'hFFFF};
    line = line_pat(8'h00);
    in_req_valid = 1; in_req_rw = 1; in_req_addr = 26'h100; in_req_tag = 8'h09;
    in_req_byteen = 64'hFFFF_0000_FFFF_00FF; in_req_data = line; out_req_ready = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if ({out_req_valid, out_req_rw, out_req_last, in_req_ready} !== {2'b11, k == 3, k == 0}) begin
        n_fail++; $display("FAIL write_ctrl beat %0d: got %b expected %b", k,
          {out_req_valid, out_req_rw, out_req_last, in_req_ready}, {2'b11, k == 3, k == 0});
      end
      n_checks++;
      if ({out_req_addr, out_req_byteen, out_req_tag} !== {26'h100, 2'(k), exp_be[k], 8'h09}) begin
        n_fail++; $display("FAIL write_beat %0d: got addr %h be %h tag %h expected addr %h be %h tag 09",
          k, out_req_addr, out_req_byteen, out_req_tag, {26'h100, 2'(k)}, exp_be[k]);
      end
      n_checks++;
      if (out_req_data !== line[k*128 +: 128]) begin
        n_fail++; $display("FAIL write_data %0d: got %h expected %h", k, out_req_data, line[k*128 +: 128]);
      end
      @(posedge clk); #1;
      if (k == 0) in_req_valid = 0;
    end
    @(negedge clk);
    n_checks++;
    if (out_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL write_done: out_req_valid %b expected 0", out_req_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [511:0] line;
    int exp_k;
    line = line_pat(8'hA5);
    exp_k = 0;
    in_req_valid = 1; in_req_rw = 1; in_req_addr = 26'h2AB; in_req_tag = 8'h33;
    in_req_byteen = '1; in_req_data = line;
    for (int cyc = 0; cyc < 12 && exp_k < 4; cyc++) begin
      out_req_ready = (cyc % 2 == 0);
      @(negedge clk);
      n_checks++;
      if ({out_req_valid, out_req_last, out_req_addr, out_req_data} !==
          {1'b1, exp_k == 3, 26'h2AB, 2'(exp_k), line[exp_k*128 +: 128]}) begin
        n_fail++; $display("FAIL bp_beat cycle %0d: got valid %b last %b addr %h expected beat %0d",
          cyc, out_req_valid, out_req_last, out_req_addr, exp_k);
      end
      @(posedge clk); #1;
      if (cyc == 0) in_req_valid = 0;
      if (out_req_ready) exp_k++;
    end
    out_req_ready = 1;
    @(negedge clk);
    n_checks++;
    if (out_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_no_dup: out_req_valid %b expected 0 after 4 beats", out_req_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rsp_stall();
    logic [511:0] line_a, line_b;
    line_a = {beat_pat(8'hA3), beat_pat(8'hA2), beat_pat(8'hA1), beat_pat(8'hA0)};
    line_b = {beat_pat(8'hB3), beat_pat(8'hB2), beat_pat(8'hB1), beat_pat(8'hB0)};
    in_rsp_ready = 0;
    for (int k = 0; k < 4; k++) send_rsp(beat_pat(8'(8'hA0 + k)), 8'h11, k == 3);
    out_rsp_valid = 1; out_rsp_data = beat_pat(8'hB0); out_rsp_tag = 8'h22; out_rsp_last = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if ({out_rsp_ready, in_rsp_valid, in_rsp_tag, in_rsp_data} !== {2'b01, 8'h11, line_a}) begin
        n_fail++; $display("FAIL stall_hold cycle %0d: ready %b valid %b tag %h data %h", c,
          out_rsp_ready, in_rsp_valid, in_rsp_tag, in_rsp_data);
      end
      @(posedge clk); #1;
    end
    in_rsp_ready = 1;
    @(negedge clk);
    n_checks++;
    if (out_rsp_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_release: out_rsp_ready %b expected 1", out_rsp_ready);
    end
    @(posedge clk); #1;
    out_rsp_valid = 0;
    n_checks++;
    if (in_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_consumed: in_rsp_valid %b expected 0", in_rsp_valid);
    end
    for (int k = 1; k < 4; k++) send_rsp(beat_pat(8'(8'hB0 + k)), 8'h22, k == 3);
    n_checks++;
    if ({in_rsp_valid, in_rsp_tag, in_rsp_data} !== {1'b1, 8'h22, line_b}) begin
      n_fail++; $display("FAIL stall_second_line: valid %b tag %h data %h expected 1 22 %h",
        in_rsp_valid, in_rsp_tag, in_rsp_data, line_b);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [511:0] exp_line;
    time t0;
    in_rsp_ready = 1;
    t0 = $time;
    for (int l = 0; l < 2; l++) begin
      for (int k = 0; k < 4; k++) send_rsp(beat_pat(8'(8'h40 + 8'h10 * l + k)), 8'(8'h40 + l), k == 3);
      exp_line = {beat_pat(8'(8'h43 + 8'h10 * l)), beat_pat(8'(8'h42 + 8'h10 * l)),
                  beat_pat(8'(8'h41 + 8'h10 * l)), beat_pat(8'(8'h40 + 8'h10 * l))};
      n_checks++;
      if ({in_rsp_valid, in_rsp_tag, in_rsp_data} !== {1'b1, 8'(8'h40 + l), exp_line}) begin
        n_fail++; $display("FAIL b2b_line %0d: valid %b tag %h data %h", l, in_rsp_valid, in_rsp_tag, in_rsp_data);
      end
    end
    n_checks++;
    if (($time - t0) / 10 != 8) begin
      n_fail++; $display("FAIL b2b_throughput: took %0d cycles expected 8", ($time - t0) / 10);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_burst();
    logic [511:0] exp_line;
    in_req_valid = 1; in_req_rw = 1; in_req_addr = 26'h3C; in_req_tag = 8'h5A;
    in_req_byteen = '1; in_req_data = line_pat(8'h3C); out_req_ready = 1;
    @(posedge clk); #1 in_req_valid = 0;
    @(posedge clk); #1;
    reset = 1; #1;
    n_checks++;
    if ({out_req_valid, in_req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL reset_wr_outputs: valid %b ready %b expected 0 1", out_req_valid, in_req_ready);
    end
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    n_checks++;
    if (out_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_wr_no_beat: out_req_valid %b expected 0", out_req_valid);
    end
    @(posedge clk); #1;
    in_rsp_ready = 0;
    send_rsp(beat_pat(8'hF0), 8'h66, 1'b0);
    send_rsp(beat_pat(8'hF1), 8'h66, 1'b0);
    reset = 1; #1;
    n_checks++;
    if ({in_rsp_valid, out_rsp_ready} !== 2'b01) begin
      n_fail++; $display("FAIL reset_rd_outputs: valid %b ready %b expected 0 1", in_rsp_valid, out_rsp_ready);
    end
    @(posedge clk); #1 reset = 0;
    in_req_valid = 1; in_req_rw = 0; in_req_addr = 26'h3FF_FFFF; in_req_tag = 8'h77;
    #1;
    n_checks++;
    if ({out_req_valid, out_req_last, out_req_addr} !== {2'b11, 28'hFFF_FFFC}) begin
      n_fail++; $display("FAIL reset_next_read_req: valid %b last %b addr %h expected 1 1 ffffffc",
        out_req_valid, out_req_last, out_req_addr);
    end
    @(posedge clk); #1 in_req_valid = 0;
    for (int k = 0; k < 4; k++) send_rsp(beat_pat(8'(8'hE0 + k)), 8'h77, k == 3);
    exp_line = {beat_pat(8'hE3), beat_pat(8'hE2), beat_pat(8'hE1), beat_pat(8'hE0)};
    n_checks++;
    if ({in_rsp_valid, in_rsp_tag, in_rsp_data} !== {1'b1, 8'h77, exp_line}) begin
      n_fail++; $display("FAIL reset_next_read_rsp: valid %b tag %h data %h expected %h",
        in_rsp_valid, in_rsp_tag, in_rsp_data, exp_line);
    end
    in_rsp_ready = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_beat();
    logic [511:0] line;
    line = line_pat(8'h5C);
    b_in_req_valid = 1; b_in_req_rw = 0; b_in_req_addr = 26'h155; b_in_req_tag = 8'd7;
    b_in_req_byteen = '0; b_in_req_data = line; b_out_req_ready = 1;
    #1;
    n_checks++;
    if ({b_out_req_valid, b_out_req_rw, b_out_req_last, b_in_req_ready, b_out_req_addr, b_out_req_byteen}
        !== {4'b1011, 27'h2AA, 64'hFFFF_FFFF_FFFF_FFFF}) begin
      n_fail++; $display("FAIL b1_read: ctrl %b addr %h be %h expected 1011 2aa all-ones",
        {b_out_req_valid, b_out_req_rw, b_out_req_last, b_in_req_ready}, b_out_req_addr, b_out_req_byteen);
    end
    n_checks++;
    if (b_out_req_data !== line) begin
      n_fail++; $display("FAIL b1_read_data: got %h expected %h", b_out_req_data, line);
    end
    b_in_req_rw = 1; b_in_req_byteen = 64'hFFFF_0000_FFFF_00FF; #1;
    n_checks++;
    if ({b_out_req_rw, b_out_req_last, b_out_req_byteen, b_out_req_tag} !== {2'b11, 64'hFFFF_0000_FFFF_00FF, 8'd7}) begin
      n_fail++; $display("FAIL b1_write: rw %b last %b be %h tag %h", b_out_req_rw, b_out_req_last,
        b_out_req_byteen, b_out_req_tag);
    end
    b_out_req_ready = 0; #1;
    n_checks++;
    if (b_in_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL b1_ready_follow: got %b expected 0", b_in_req_ready);
    end
    b_out_req_ready = 1;
    @(posedge clk); #1 b_in_req_valid = 0;
    @(negedge clk);
    n_checks++;
    if ({b_out_req_valid, b_in_req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL b1_write_done: valid %b ready %b expected 0 1", b_out_req_valid, b_in_req_ready);
    end
    @(posedge clk); #1;
    b_in_rsp_ready = 0;
    b_out_rsp_valid = 1; b_out_rsp_data = line_pat(8'h77); b_out_rsp_tag = 8'd9; b_out_rsp_last = 1;
    @(negedge clk);
    n_checks++;
    if ({b_out_rsp_ready, b_in_rsp_valid} !== 2'b10) begin
      n_fail++; $display("FAIL b1_rsp_before: ready %b valid %b expected 1 0", b_out_rsp_ready, b_in_rsp_valid);
    end
    @(posedge clk); #1 b_out_rsp_valid = 0; b_out_rsp_last = 0;
    n_checks++;
    if ({b_in_rsp_valid, b_in_rsp_tag, b_in_rsp_data} !== {1'b1, 8'd9, line_pat(8'h77)}) begin
      n_fail++; $display("FAIL b1_rsp: valid %b tag %h data %h", b_in_rsp_valid, b_in_rsp_tag, b_in_rsp_data);
    end
    b_in_rsp_ready = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_backpressure();
    test_rsp_stall();
    test_back_to_back();
    test_reset_mid_burst();
    test_single_beat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
